// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader
// Purpose  : Byte-stream program loader. Receives a 16-bit little-endian word
//            count N followed by N*BPW image bytes over a valid/ready byte
//            interface. Each completed word is written little-endian into
//            instruction memory from address 0 upward. The CPU is held in
//            reset until the image is complete.
// Ports    : clk, rst        - clock (rising edge), async active-high reset
//            in_data/valid   - image byte stream input
//            in_ready        - byte accepted when in_valid & in_ready
//            imem_we/addr/wdata - instruction memory write port (1 cycle/word)
//            cpu_hold        - high keeps the CPU in reset
//            load_done       - image loaded, CPU running
//            overflow        - sticky, image longer than memory depth
//            words_loaded    - words written during the current load
//            reload          - start a new load (honoured only when done)
// Revision : 1.0 - initial release
// ============================================================================
module boot_loader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              overflow,
   output logic [15:0]       words_loaded,
   input  logic              reload
);

   localparam int BPW    = DATA_W / 8;
   localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

   localparam logic [BIDX_W-1:0] c_LAST_BYTE = BIDX_W'(BPW - 1);
   // Wide enough to hold 2^ADDR_W without wrapping.
   localparam logic [32:0]       c_DEPTH     = 33'd1 << ADDR_W;

   typedef enum logic [1:0] {
      HDR_LO = 2'd0,
      HDR_HI = 2'd1,
      DATA   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              r_state,     w_state;
   logic [15:0]         r_n,         w_n;
   logic [BIDX_W-1:0]   r_byte_idx,  w_byte_idx;
   logic [15:0]         r_word_idx,  w_word_idx;
   logic [DATA_W-1:0]   r_word,      w_word;
   logic                r_we,        w_we;
   logic [ADDR_W-1:0]   r_addr,      w_addr;
   logic [DATA_W-1:0]   r_wdata,     w_wdata;
   logic                r_hold,      w_hold;
   logic                r_done,      w_done;
   logic                r_ovf,       w_ovf;
   logic [15:0]         r_loaded,    w_loaded;
   logic                r_ready,     w_ready;

   logic                w_accept;
   logic [DATA_W-1:0]   w_asm;
   logic                w_in_range;
   logic                w_last_word;

   assign w_accept    = in_valid & r_ready;
   assign w_in_range  = ({17'd0, r_word_idx} < c_DEPTH);
   assign w_last_word = (r_word_idx == (r_n - 16'd1));

   // Partial word with the incoming byte dropped into its lane.
   always_comb begin
      w_asm = r_word;
      w_asm[8*r_byte_idx +: 8] = in_data;
   end

   always_comb begin
      w_state    = r_state;
      w_n        = r_n;
      w_byte_idx = r_byte_idx;
      w_word_idx = r_word_idx;
      w_word     = r_word;
      w_we       = 1'b0;
      w_addr     = r_addr;
      w_wdata    = r_wdata;
      w_hold     = r_hold;
      w_done     = r_done;
      w_ovf      = r_ovf;
      w_loaded   = r_loaded;

      case (r_state)
         HDR_LO: begin
            if (w_accept) begin
               w_n[7:0] = in_data;
               w_state  = HDR_HI;
            end
         end
         HDR_HI: begin
            if (w_accept) begin
               w_n[15:8]  = in_data;
               w_byte_idx = '0;
               w_word_idx = '0;
               w_word     = '0;
               w_state    = ({in_data, r_n[7:0]} == 16'd0) ? DONE : DATA;
            end
         end
         DATA: begin
            if (w_accept) begin
               if (r_byte_idx == c_LAST_BYTE) begin
                  w_byte_idx = '0;
                  w_word     = '0;
                  w_word_idx = r_word_idx + 16'd1;
                  if (w_in_range) begin
                     w_we     = 1'b1;
                     w_addr   = r_word_idx[ADDR_W-1:0];
                     w_wdata  = w_asm;
                     w_loaded = r_loaded + 16'd1;
                  end else begin
                     // Excess words are drained but never written.
                     w_ovf = 1'b1;
                  end
                  if (w_last_word) begin
                     w_state = DONE;
                  end
               end else begin
                  w_word     = w_asm;
                  w_byte_idx = r_byte_idx + BIDX_W'(1);
               end
            end
         end
         DONE: begin
            if (reload) begin
               w_state    = HDR_LO;
               w_hold     = 1'b1;
               w_done     = 1'b0;
               w_ovf      = 1'b0;
               w_loaded   = '0;
               w_n        = '0;
               w_byte_idx = '0;
               w_word_idx = '0;
               w_word     = '0;
            end else begin
               // One cycle after entry, so the final write lands while held.
               w_hold = 1'b0;
               w_done = 1'b1;
            end
         end
         default: begin
            w_state = HDR_LO;
         end
      endcase

      // Registered copy of the next state's decode keeps in_ready glitch-free.
      w_ready = (w_state != DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= HDR_LO;
         r_n        <= '0;
         r_byte_idx <= '0;
         r_word_idx <= '0;
         r_word     <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_hold     <= 1'b1;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
         r_loaded   <= '0;
         r_ready    <= 1'b1;
      end else begin
         r_state    <= w_state;
         r_n        <= w_n;
         r_byte_idx <= w_byte_idx;
         r_word_idx <= w_word_idx;
         r_word     <= w_word;
         r_we       <= w_we;
         r_addr     <= w_addr;
         r_wdata    <= w_wdata;
         r_hold     <= w_hold;
         r_done     <= w_done;
         r_ovf      <= w_ovf;
         r_loaded   <= w_loaded;
         r_ready    <= w_ready;
      end
   end

   assign in_ready     = r_ready;
   assign imem_we      = r_we;
   assign imem_addr    = r_addr;
   assign imem_wdata   = r_wdata;
   assign cpu_hold     = r_hold;
   assign load_done    = r_done;
   assign overflow     = r_ovf;
   assign words_loaded = r_loaded;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_loader
// Purpose  : Self-checking bench for boot_loader. A stream-level model
//            (header bytes seen, data bytes seen, words completed) predicts
//            every output each cycle for the default-size instance; a second
//            instance with a 4-word memory exercises overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        imem_we;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        overflow;
   logic [15:0] words_loaded;
   logic        reload;

   logic        s_rst;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        s_we;
   logic [1:0]  s_addr;
   logic [31:0] s_wdata;
   logic        s_hold;
   logic        s_done;
   logic        s_ovf;
   logic [15:0] s_loaded;
   logic        s_reload;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   boot_loader dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
      .overflow(overflow), .words_loaded(words_loaded), .reload(reload)
   );

   boot_loader #(.DATA_W(32), .ADDR_W(2)) dut_s (
      .clk(clk), .rst(s_rst), .in_data(s_data), .in_valid(s_valid),
      .in_ready(s_ready), .imem_we(s_we), .imem_addr(s_addr),
      .imem_wdata(s_wdata), .cpu_hold(s_hold), .load_done(s_done),
      .overflow(s_ovf), .words_loaded(s_loaded), .reload(s_reload)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- stream-level model of the default instance -------------
   int          m_hdr;
   logic [15:0] m_n;
   int          m_db;
   logic [7:0]  m_buf [4];
   logic        e_we, e_hold, e_done, e_ovf;
   logic [9:0]  e_addr;
   logic [31:0] e_wdata;
   logic [15:0] e_loaded;

   function automatic bit m_complete();
      return (m_hdr == 2) && (m_db == 4 * int'(m_n));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hdr = 0; m_n = 0; m_db = 0;
         e_we = 0; e_addr = 0; e_wdata = 0;
         e_hold = 1; e_done = 0; e_ovf = 0; e_loaded = 0;
      end else begin
         int w;
         bit comp;
         comp = m_complete();
         e_we = 0;
         if (!comp) begin
            if (in_valid) begin
               if (m_hdr < 2) begin
                  m_n[8*m_hdr +: 8] = in_data;
                  m_hdr++;
               end else begin
                  m_buf[m_db % 4] = in_data;
                  m_db++;
                  if (m_db % 4 == 0) begin
                     w = m_db / 4 - 1;
                     if (w < 1024) begin
                        e_we     = 1;
                        e_addr   = w[9:0];
                        e_wdata  = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                        e_loaded = e_loaded + 16'd1;
                     end else begin
                        e_ovf = 1;
                     end
                  end
               end
            end
         end else if (reload) begin
            m_hdr = 0; m_n = 0; m_db = 0;
            e_hold = 1; e_done = 0; e_ovf = 0; e_loaded = 0;
         end else begin
            e_hold = 0; e_done = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready",     {63'd0, in_ready},  {63'd0, !m_complete()});
         chk("imem_we",      {63'd0, imem_we},   {63'd0, e_we});
         chk("imem_addr",    {54'd0, imem_addr}, {54'd0, e_addr});
         chk("imem_wdata",   {32'd0, imem_wdata},{32'd0, e_wdata});
         chk("cpu_hold",     {63'd0, cpu_hold},  {63'd0, e_hold});
         chk("load_done",    {63'd0, load_done}, {63'd0, e_done});
         chk("overflow",     {63'd0, overflow},  {63'd0, e_ovf});
         chk("words_loaded", {48'd0, words_loaded}, {48'd0, e_loaded});
      end
   end

   // ---------------- write capture ------------------------------------------
   logic [41:0] wq [$];
   logic [41:0] sq [$];

   always @(negedge clk) begin
      if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});
      if (s_we === 1'b1)    sq.push_back({8'd0, s_addr, s_wdata});
   end

   // ---------------- stimulus helpers (called at a negedge) -----------------
   task automatic send(input bit sel, input logic [7:0] b);
      int t = 0;
      if (sel) begin s_data = b; s_valid = 1'b1; end
      else     begin in_data = b; in_valid = 1'b1; end
      while (!(sel ? s_ready : in_ready) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("send_timeout", 64'd1, 64'd0);
      @(negedge clk);
      if (sel) s_valid = 1'b0; else in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); #2 rst = 1'b1;
      @(negedge clk); #2 rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_wq(input int idx, input logic [9:0] a, input logic [31:0] d);
      if (idx < wq.size()) chk($sformatf("write%0d", idx), {22'd0, wq[idx]}, {22'd0, a, d});
      else                 chk($sformatf("write%0d_missing", idx), 64'd0, 64'd1);
   endtask

   logic [7:0]  img1 [10] = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
   logic [31:0] s_exp [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};

   initial begin
      rst = 1'b1; in_data = 0; in_valid = 0; reload = 0;
      s_rst = 1'b1; s_data = 0; s_valid = 0; s_reload = 0;
      repeat (2) @(negedge clk);
      // Reset state, pinned by literals.
      chk("rst_hold",  {63'd0, cpu_hold}, 64'd1);
      chk("rst_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_we",    {63'd0, imem_we},  64'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Two-word image, continuous valid.
      foreach (img1[i]) send(0, img1[i]);
      chk("t1_we",    {63'd0, imem_we},    64'd1);
      chk("t1_hold",  {63'd0, cpu_hold},   64'd1);
      @(negedge clk);
      chk("t1_hold_fall", {63'd0, cpu_hold},  64'd0);
      chk("t1_done",      {63'd0, load_done}, 64'd1);
      chk("t1_loaded",    {48'd0, words_loaded}, 64'd2);
      chk("t1_ovf",       {63'd0, overflow},  64'd0);
      chk("t1_nwrites",   64'(wq.size()), 64'd2);
      chk_wq(0, 10'd0, 32'h44332211);
      chk_wq(1, 10'd1, 32'h88776655);

      // Reload, then a one-word image with an ignored reload inside DATA.
      reload = 1'b1; @(negedge clk); reload = 1'b0;
      chk("t6_hold",   {63'd0, cpu_hold},  64'd1);
      chk("t6_done",   {63'd0, load_done}, 64'd0);
      chk("t6_loaded", {48'd0, words_loaded}, 64'd0);
      wq.delete();
      send(0, 8'h01); send(0, 8'h00); send(0, 8'hEF); send(0, 8'hBE);
      reload = 1'b1; @(negedge clk); reload = 1'b0;
      send(0, 8'hAD); send(0, 8'hDE);
      chk("t6_loaded1", {48'd0, words_loaded}, 64'd1);
      @(negedge clk);
      chk("t6_done1",   {63'd0, load_done}, 64'd1);
      chk("t6_nwrites", 64'(wq.size()), 64'd1);
      chk_wq(0, 10'd0, 32'hDEADBEEF);

      // Empty image.
      do_reset();
      wq.delete();
      send(0, 8'h00); send(0, 8'h00);
      chk("t2_hold",  {63'd0, cpu_hold}, 64'd1);
      chk("t2_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      chk("t2_hold_fall", {63'd0, cpu_hold},  64'd0);
      chk("t2_done",      {63'd0, load_done}, 64'd1);
      chk("t2_nwrites",   64'(wq.size()), 64'd0);

      // Same image as the first with random stalls.
      do_reset();
      wq.delete();
      foreach (img1[i]) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         send(0, img1[i]);
      end
      repeat (2) @(negedge clk);
      chk("t3_nwrites", 64'(wq.size()), 64'd2);
      chk_wq(0, 10'd0, 32'h44332211);
      chk_wq(1, 10'd1, 32'h88776655);

      // Reset in the middle of the second word.
      do_reset();
      send(0, 8'h02); send(0, 8'h00);
      for (int i = 0; i < 5; i++) send(0, 8'(8'h11 * (i + 1)));
      #2 rst = 1'b1;
      #1;
      chk("t5_hold",   {63'd0, cpu_hold},     64'd1);
      chk("t5_ready",  {63'd0, in_ready},     64'd1);
      chk("t5_we",     {63'd0, imem_we},      64'd0);
      chk("t5_addr",   {54'd0, imem_addr},    64'd0);
      chk("t5_wdata",  {32'd0, imem_wdata},   64'd0);
      chk("t5_done",   {63'd0, load_done},    64'd0);
      chk("t5_loaded", {48'd0, words_loaded}, 64'd0);
      wq.delete();
      @(negedge clk);
      @(negedge clk); #2 rst = 1'b0;
      @(negedge clk);
      chk("t5_nowrite", 64'(wq.size()), 64'd0);
      send(0, 8'h01); send(0, 8'h00); send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hCC); send(0, 8'hDD);
      @(negedge clk);
      chk("t5_nwrites", 64'(wq.size()), 64'd1);
      chk_wq(0, 10'd0, 32'hDDCCBBAA);

      // Overflow on a 4-word memory.
      s_rst = 1'b0;
      @(negedge clk);
      send(1, 8'h06); send(1, 8'h00);
      for (int i = 0; i < 24; i++) send(1, 8'(i + 1));
      chk("t4_ovf",    {63'd0, s_ovf},    64'd1);
      chk("t4_loaded", {48'd0, s_loaded}, 64'd4);
      chk("t4_ready",  {63'd0, s_ready},  64'd0);
      chk("t4_hold",   {63'd0, s_hold},   64'd1);
      @(negedge clk);
      chk("t4_done",   {63'd0, s_done},   64'd1);
      chk("t4_nwrites", 64'(sq.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < sq.size()) chk($sformatf("t4_write%0d", i), {22'd0, sq[i]}, {30'd0, 2'(i), s_exp[i]});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Byte-stream program loader sitting directly upstream of the CPU core.
- Receives a length-prefixed image over a valid/ready byte interface and writes 32-bit little-endian words into instruction memory starting at address 0.
- Holds the CPU in reset (cpu_hold) until the image is complete, then releases it.
- Replaces preloaded instruction memory as the way programs reach the core in system-level simulation.

Parameters:
- DATA_W, 32, instruction word width; must be a multiple of 8; BPW = DATA_W/8 bytes per word.
- ADDR_W, 10, instruction memory address width; memory depth DEPTH = 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_data  in  8  image byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle; transfer = in_valid & in_ready
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  DATA_W  write data
- cpu_hold  out  1  high keeps the CPU in reset
- load_done  out  1  image loaded, CPU running
- overflow  out  1  sticky; image had more than DEPTH words
- words_loaded  out  16  words written to memory in the current load
- reload  in  1  single-cycle request to start a new load; honoured only in DONE

Behaviour:
- Reset (async, rst=1):
  - state = HDR_LO.
  - cpu_hold=1; in_ready=1.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - load_done=0, overflow=0, words_loaded=0.
  - Byte and word counters cleared.
- All outputs are registered; in_ready is decoded from state only, with no combinational path from in_valid.
- States: HDR_LO, HDR_HI, DATA, DONE.
- HDR_LO:
  - in_ready=1.
  - Accepted byte -> N[7:0]; go to HDR_HI.
- HDR_HI:
  - in_ready=1.
  - Accepted byte -> N[15:8].
  - If N=0, go to DONE; otherwise go to DATA with byte_idx=0, word_idx=0.
- DATA:
  - in_ready=1.
  - Byte k of a word (k=0..BPW-1) is placed at bits [8k+7:8k] (little-endian).
  - On acceptance of byte BPW-1, if word_idx < DEPTH:
    - imem_we=1 for exactly the next cycle;
    - imem_addr = word_idx[ADDR_W-1:0];
    - imem_wdata = assembled word;
    - words_loaded increments at that same edge.
  - On acceptance of byte BPW-1, if word_idx >= DEPTH: no write and overflow is set (sticky). The bytes are still consumed.
  - word_idx increments after each complete word.
  - On the last byte of word N-1, go to DONE at the same edge that raises imem_we.
- DONE:
  - in_ready=0.
  - cpu_hold falls exactly one cycle after DONE is entered; load_done rises at that same edge.
  - imem_we and cpu_hold are therefore never high-then-low in the same cycle; the last write always completes while the CPU is held.
- reload=1 in DONE:
  - next edge: state=HDR_LO, cpu_hold=1, load_done=0;
  - overflow, words_loaded and counters are cleared.
- reload in any other state is ignored.
- in_valid low in any accepting state: state, counters and partial word are held; stalls of any length are legal.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Reset mid-load aborts immediately:
  - no further writes;
  - a partial word is discarded;
  - the memory contents already written are left as-is.

Test Plan:
1. Reset, then stream 02 00 11 22 33 44 55 66 77 88 with continuous valid -> two imem_we pulses: addr0=0x44332211, addr1=0x88776655. Then cpu_hold falls one cycle after the second pulse, with load_done=1, words_loaded=2, overflow=0.
2. Header 00 00 -> no imem_we. cpu_hold falls one cycle after DONE is entered (two edges after the second header byte is accepted); in_ready=0 thereafter.
3. Same image as 1 with random in_valid gaps (0–5 cycles) -> identical writes, exactly one imem_we per word, no duplicate or missing bytes.
4. ADDR_W=2, header 06 00, 24 data bytes -> writes only to addr 0..3. The last 8 bytes are consumed without a write; overflow=1, words_loaded=4, then DONE.
5. Assert rst after 5 data bytes of a 2-word load -> all outputs return to reset values immediately with no further imem_we. A fresh 01 00 AA BB CC DD then writes addr0=0xDDCCBBAA.
6. After test 1 completes, pulse reload -> cpu_hold=1 next cycle. A new image 01 00 EF BE AD DE writes addr0=0xDEADBEEF and words_loaded=1. A reload pulse issued during DATA has no effect.
